// File: rtl/core_endop_monitor.sv
// core_endop_monitor
//   Run-completion monitor for the multi-core build. It watches each core's
//   instruction bus for ENDOP_CODE. When the completion term is met (all
//   enabled cores ended, or any one, depending on MODE) it waits DRAIN_CYCLES
//   edges and then raises done/halt_req. A watchdog on the RUN cycle count
//   raises timeout instead if completion never arrives.
// Ports
//   i_clk, i_rst    clock (rising edge), async active-high reset
//   i_start         1-cycle arm pulse, honoured in IDLE/DONE/TIMEOUT only
//   i_core_en       per-core enable, captured into the core mask on start
//   i_ins           packed instruction buses, core i = i_ins[i*INS_W +: INS_W]
//   o_busy          RUN or DRAIN
//   o_done          DONE
//   o_timeout       TIMEOUT
//   o_halt_req      DONE or TIMEOUT
//   o_core_done     sticky per-core ENDOP-seen flags
//   o_first_core    lowest index among the cores that ended first
//   o_cycle_count   edges spent in RUN, frozen after RUN

// Per-core ENDOP detector; disabled cores never report a hit.
module core_endop_lane #(
    parameter int               INS_W      = 8,
    parameter logic [INS_W-1:0] ENDOP_CODE = INS_W'(28)
) (
    input  logic             i_en,
    input  logic [INS_W-1:0] i_ins,
    output logic             o_hit
);
    assign o_hit = i_en && (i_ins == ENDOP_CODE);
endmodule

module core_endop_monitor #(
    parameter int               NUM_CORES      = 4,
    parameter int               INS_W          = 8,
    parameter logic [INS_W-1:0] ENDOP_CODE     = INS_W'(28),
    parameter int               MODE           = 0,
    parameter int               DRAIN_CYCLES   = 5,
    parameter int               CNT_W          = 24,
    parameter int               TIMEOUT_CYCLES = 100000,
    parameter int               IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [NUM_CORES-1:0]       i_core_en,
    input  logic [NUM_CORES*INS_W-1:0] i_ins,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_timeout,
    output logic                       o_halt_req,
    output logic [NUM_CORES-1:0]       o_core_done,
    output logic [IDX_W-1:0]           o_first_core,
    output logic [CNT_W-1:0]           o_cycle_count
);
    localparam int               DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    // Watchdog fires on the edge that would take the count to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_CORES-1:0] r_core_mask, r_core_done;
    logic [NUM_CORES-1:0] w_hit, w_nd;
    logic [IDX_W-1:0]     r_first_core, w_first_idx;
    logic [CNT_W-1:0]     r_cycle_count;
    logic [DW-1:0]        r_drain_cnt;
    logic                 w_complete, w_first_rise, w_armable;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
        core_endop_lane #(
            .INS_W      (INS_W),
            .ENDOP_CODE (ENDOP_CODE)
        ) u_lane (
            .i_en  (r_core_mask[gi]),
            .i_ins (i_ins[gi*INS_W +: INS_W]),
            .o_hit (w_hit[gi])
        );
    end

    // Completion and first-core logic look at the flags as they will be
    // after this edge, so an ENDOP counts on the edge it is sampled.
    assign w_nd         = r_core_done | w_hit;
    assign w_first_rise = (r_core_done == '0) && (w_nd != '0);
    assign w_armable    = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);

    always_comb begin
        w_complete = 1'b0;
        if (MODE == 0) w_complete = ((w_nd & r_core_mask) == r_core_mask);
        else           w_complete = |(w_nd & r_core_mask);
    end

    // Lowest set bit; w_nd only holds the newly risen bits when w_first_rise.
    always_comb begin
        w_first_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_nd[i]) w_first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (i_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Completion has priority over the watchdog on the same edge.
                if (w_complete)                  w_state_nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                else if (r_cycle_count == TO_LAST) w_state_nxt = S_TIMEOUT;
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_core_mask   <= '0;
            r_core_done   <= '0;
            r_first_core  <= '0;
            r_cycle_count <= '0;
            r_drain_cnt   <= '0;
        end else if (w_armable) begin
            if (i_start) begin
                r_core_mask   <= i_core_en;
                r_core_done   <= '0;
                r_first_core  <= '0;
                r_cycle_count <= '0;
                r_drain_cnt   <= '0;
            end
        end else begin
            // RUN or DRAIN: flags keep latching late ENDOPs in both.
            r_core_done <= w_nd;
            if (w_first_rise) r_first_core <= w_first_idx;
            if (r_state == S_RUN) r_cycle_count <= r_cycle_count + 1'b1;
            else                  r_drain_cnt   <= r_drain_cnt + 1'b1;
        end
    end

    assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done        = (r_state == S_DONE);
    assign o_timeout     = (r_state == S_TIMEOUT);
    assign o_halt_req    = (r_state == S_DONE) || (r_state == S_TIMEOUT);
    assign o_core_done   = r_core_done;
    assign o_first_core  = r_first_core;
    assign o_cycle_count = r_cycle_count;
endmodule

// File: tb/tb_core_endop_monitor.sv
// Bench for core_endop_monitor. Three builds share one stimulus stream:
//   k=0: MODE0, DRAIN 5;  k=1: MODE1, DRAIN 5;  k=2: MODE0, DRAIN 0
// all with TIMEOUT_CYCLES=50. A behavioural model per build is compared
// every negedge; directed literal checks pin the model at key points.
module tb_core_endop_monitor;
    localparam int NB = 3;
    localparam int TO = 50;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3, P_TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  core_en = 4'h0;
    logic [31:0] ins = 32'h0;
    logic [7:0]  lane [4];

    logic        busy [NB];
    logic        done [NB];
    logic        tmo  [NB];
    logic        halt [NB];
    logic [3:0]  cd   [NB];
    logic [1:0]  fc   [NB];
    logic [23:0] cnt  [NB];

    int md [NB] = '{0, 1, 0};
    int dr [NB] = '{5, 5, 0};

    int         m_ph   [NB];
    logic [3:0] m_cd   [NB];
    logic [3:0] m_mask [NB];
    int         m_first[NB];
    int         m_cnt  [NB];
    int         m_left [NB];

    int n_chk = 0;
    int n_err = 0;
    int tcount = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    core_endop_monitor #(.MODE(0), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(TO)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_core_en(core_en), .i_ins(ins),
        .o_busy(busy[0]), .o_done(done[0]), .o_timeout(tmo[0]), .o_halt_req(halt[0]),
        .o_core_done(cd[0]), .o_first_core(fc[0]), .o_cycle_count(cnt[0]));
    core_endop_monitor #(.MODE(1), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(TO)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_core_en(core_en), .i_ins(ins),
        .o_busy(busy[1]), .o_done(done[1]), .o_timeout(tmo[1]), .o_halt_req(halt[1]),
        .o_core_done(cd[1]), .o_first_core(fc[1]), .o_cycle_count(cnt[1]));
    core_endop_monitor #(.MODE(0), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(TO)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_core_en(core_en), .i_ins(ins),
        .o_busy(busy[2]), .o_done(done[2]), .o_timeout(tmo[2]), .o_halt_req(halt[2]),
        .o_core_done(cd[2]), .o_first_core(fc[2]), .o_cycle_count(cnt[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] noise(int t, int i);
        logic [7:0] v;
        v = 8'((t * 13 + i * 5 + 1) & 255);
        if (v == 8'd28) v = 8'd29;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_ph[k] = P_IDLE; m_cd[k] = 4'h0; m_mask[k] = 4'h0;
            m_first[k] = 0; m_cnt[k] = 0; m_left[k] = 0;
        end
    endtask

    // One clock edge of the specification's behaviour, using the inputs held now.
    task automatic model_step();
        logic [3:0] hits;
        bit         fin;
        for (int k = 0; k < NB; k++) begin
            if (m_ph[k] == P_IDLE || m_ph[k] == P_DONE || m_ph[k] == P_TO) begin
                if (start) begin
                    m_ph[k] = P_RUN; m_cd[k] = 4'h0; m_cnt[k] = 0;
                    m_first[k] = 0; m_mask[k] = core_en;
                end
            end else begin
                hits = 4'h0;
                for (int i = 0; i < 4; i++)
                    if (m_mask[k][i] && lane[i] == 8'd28) hits[i] = 1'b1;
                if (m_cd[k] == 4'h0 && hits != 4'h0) begin
                    for (int i = 3; i >= 0; i--) if (hits[i]) m_first[k] = i;
                end
                m_cd[k] = m_cd[k] | hits;
                if (m_ph[k] == P_RUN) begin
                    m_cnt[k]++;
                    fin = 1'b1;
                    if (md[k] == 0) begin
                        for (int i = 0; i < 4; i++) if (m_mask[k][i] && !m_cd[k][i]) fin = 1'b0;
                    end else begin
                        fin = 1'b0;
                        for (int i = 0; i < 4; i++) if (m_mask[k][i] && m_cd[k][i]) fin = 1'b1;
                    end
                    if (fin) begin
                        if (dr[k] == 0) m_ph[k] = P_DONE;
                        else begin m_ph[k] = P_DRAIN; m_left[k] = dr[k]; end
                    end else if (m_cnt[k] == TO) m_ph[k] = P_TO;
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_ph[k] = P_DONE;
                end
            end
        end
    endtask

    // Drive one cycle: start, and ENDOP on the cores in em; other lanes carry noise.
    task automatic cyc(input logic st, input logic [3:0] em);
        start = st;
        for (int i = 0; i < 4; i++) lane[i] = em[i] ? 8'd28 : noise(tcount, i);
        ins = {lane[3], lane[2], lane[1], lane[0]};
        tcount++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic zero_checks(input string tag);
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
            chk($sformatf("%s_done%0d", tag, k), 32'(done[k]), 0);
            chk($sformatf("%s_tmo%0d", tag, k),  32'(tmo[k]), 0);
            chk($sformatf("%s_halt%0d", tag, k), 32'(halt[k]), 0);
            chk($sformatf("%s_cd%0d", tag, k),   32'(cd[k]), 0);
            chk($sformatf("%s_fc%0d", tag, k),   32'(fc[k]), 0);
            chk($sformatf("%s_cnt%0d", tag, k),  32'(cnt[k]), 0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            for (int k = 0; k < NB; k++) begin
                chk($sformatf("m_busy%0d", k), 32'(busy[k]), 32'(m_ph[k] == P_RUN || m_ph[k] == P_DRAIN));
                chk($sformatf("m_done%0d", k), 32'(done[k]), 32'(m_ph[k] == P_DONE));
                chk($sformatf("m_tmo%0d", k),  32'(tmo[k]),  32'(m_ph[k] == P_TO));
                chk($sformatf("m_halt%0d", k), 32'(halt[k]), 32'(m_ph[k] == P_DONE || m_ph[k] == P_TO));
                chk($sformatf("m_cd%0d", k),   32'(cd[k]),   32'(m_cd[k]));
                chk($sformatf("m_fc%0d", k),   32'(fc[k]),   32'(m_first[k]));
                chk($sformatf("m_cnt%0d", k),  32'(cnt[k]),  32'(m_cnt[k]));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) lane[i] = 8'h0;
        model_reset();
        repeat (2) @(negedge clk);
        zero_checks("rst0");
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // Async reset mid-RUN (and mid-DRAIN on the MODE1 build).
        core_en = 4'hF;
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0001);
        cyc(1'b0, 4'b0010);
        chk("t1_cd_pre", 32'(cd[0]), 32'h3);
        chk("t1_busy_pre", 32'(busy[0]), 1);
        #2 rst = 1'b1;
        #1 model_reset();
        zero_checks("t1rst");
        @(negedge clk);
        #1 rst = 1'b0;

        // MODE0 staggered ENDOPs.
        core_en = 4'hF;
        cyc(1'b1, 4'b0000);
        for (int c = 0; c <= 30; c++) begin
            cyc(1'b0, (c == 10) ? 4'b0100 : (c == 12) ? 4'b0001 :
                      (c == 15) ? 4'b1000 : (c == 20) ? 4'b0010 : 4'b0000);
            if (c == 10) begin
                chk("t2_cd10", 32'(cd[0]), 32'b0100);
                chk("t2_fc10", 32'(fc[0]), 2);
                chk("t2_b_busy10", 32'(busy[1]), 1);
            end
            if (c == 12) chk("t2_cd12", 32'(cd[0]), 32'b0101);
            if (c == 15) begin
                chk("t2_cd15", 32'(cd[0]), 32'b1101);
                chk("t2_b_done15", 32'(done[1]), 1);
            end
            if (c == 20) begin
                chk("t2_cd20", 32'(cd[0]), 32'b1111);
                chk("t2_cnt20", 32'(cnt[0]), 21);
                chk("t2_done20", 32'(done[0]), 0);
                chk("t2_c_done20", 32'(done[2]), 1);
            end
            if (c == 24) chk("t2_done24", 32'(done[0]), 0);
            if (c == 25) begin
                chk("t2_done25", 32'(done[0]), 1);
                chk("t2_halt25", 32'(halt[0]), 1);
                chk("t2_cnt25", 32'(cnt[0]), 21);
                chk("t2_fc25", 32'(fc[0]), 2);
            end
        end

        // MODE1 with a partial mask.
        core_en = 4'b1010;
        cyc(1'b1, 4'b0000);
        for (int c = 0; c <= 14; c++) begin
            cyc(1'b0, (c == 3) ? 4'b0001 : (c == 7) ? 4'b1010 : (c == 9) ? 4'b0001 : 4'b0000);
            if (c == 3) chk("t3_cd3", 32'(cd[1]), 0);
            if (c == 7) begin
                chk("t3_cd7", 32'(cd[1]), 32'b1010);
                chk("t3_fc7", 32'(fc[1]), 1);
            end
            if (c == 9)  chk("t3_cd9", 32'(cd[1]), 32'b1010);
            if (c == 11) chk("t3_done11", 32'(done[1]), 0);
            if (c == 12) chk("t3_done12", 32'(done[1]), 1);
        end

        // Watchdog with no ENDOP.
        core_en = 4'hF;
        cyc(1'b1, 4'b0000);
        for (int c = 0; c <= 51; c++) begin
            cyc(1'b0, 4'b0000);
            if (c == 48) begin
                chk("t4_tmo48", 32'(tmo[0]), 0);
                chk("t4_cnt48", 32'(cnt[0]), 49);
            end
            if (c == 49) begin
                chk("t4_tmo49", 32'(tmo[0]), 1);
                chk("t4_halt49", 32'(halt[0]), 1);
                chk("t4_done49", 32'(done[0]), 0);
                chk("t4_cnt49", 32'(cnt[0]), 50);
                chk("t4_b_tmo49", 32'(tmo[1]), 1);
            end
            if (c == 51) chk("t4_cnt51", 32'(cnt[0]), 50);
        end

        // Last ENDOP on the watchdog edge: completion wins.
        cyc(1'b1, 4'b0000);
        for (int c = 0; c <= 56; c++) begin
            cyc(1'b0, (c == 5) ? 4'b0111 : (c == 49) ? 4'b1000 : 4'b0000);
            if (c == 10) chk("t4b_b_done10", 32'(done[1]), 1);
            if (c == 49) begin
                chk("t4b_tmo49", 32'(tmo[0]), 0);
                chk("t4b_busy49", 32'(busy[0]), 1);
                chk("t4b_cnt49", 32'(cnt[0]), 50);
            end
            if (c == 54) chk("t4b_done54", 32'(done[0]), 1);
        end

        // Start ignored in DRAIN, honoured in DONE.
        core_en = 4'hF;
        cyc(1'b1, 4'b0000);
        for (int c = 0; c <= 17; c++) begin
            cyc((c == 3) || (c == 9), (c == 2 || c == 11) ? 4'b1111 : 4'b0000);
            if (c == 2) chk("t5_c_done2", 32'(done[2]), 1);
            if (c == 3) begin
                chk("t5_busy3", 32'(busy[0]), 1);
                chk("t5_done3", 32'(done[0]), 0);
                chk("t5_cnt3", 32'(cnt[0]), 3);
                chk("t5_c_busy3", 32'(busy[2]), 1);
                chk("t5_c_cd3", 32'(cd[2]), 0);
            end
            if (c == 7) chk("t5_done7", 32'(done[0]), 1);
            if (c == 9) begin
                chk("t5_busy9", 32'(busy[0]), 1);
                chk("t5_done9", 32'(done[0]), 0);
                chk("t5_cd9", 32'(cd[0]), 0);
                chk("t5_cnt9", 32'(cnt[0]), 0);
            end
            if (c == 10) chk("t5_cnt10", 32'(cnt[0]), 1);
        end

        // Empty mask: MODE0 completes at once, MODE1 times out.
        core_en = 4'h0;
        cyc(1'b1, 4'b0000);
        for (int c = 0; c <= 51; c++) begin
            cyc(1'b0, 4'b1111);
            if (c == 0) begin
                chk("t6_busy0", 32'(busy[0]), 1);
                chk("t6_cnt0", 32'(cnt[0]), 1);
            end
            if (c == 4) chk("t6_done4", 32'(done[0]), 0);
            if (c == 5) chk("t6_done5", 32'(done[0]), 1);
            if (c == 48) chk("t6_b_busy48", 32'(busy[1]), 1);
            if (c == 49) begin
                chk("t6_b_tmo49", 32'(tmo[1]), 1);
                chk("t6_b_cd49", 32'(cd[1]), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
